// File: rtl/fifo_pkg.sv
// Shared defaults for the multi-channel FIFO and a channel-index width helper.
// Compile-time only; no latency or flow control of its own.
package fifo_pkg;

    localparam int DWIDTH_DEF   = 16;
    localparam int AWIDTH_DEF   = 4;
    localparam int CHANNELS_DEF = 4;

    function automatic int ch_w(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/fifo_mc_ram.sv
// Simple dual-port memory, one write and one registered read port, no reset.
// Read data appears one edge after re_i and holds while re_i is low.
module fifo_mc_ram
    import fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int ADDR_W = AWIDTH_DEF + 2
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem [0:(1 << ADDR_W) - 1];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_mc.sv
// CHANNELS independent circular queues sharing one RAM; 1-cycle read latency.
// Writes to a full channel and reads from an empty one are dropped and flagged sticky.
module fifo_mc
    import fifo_pkg::*;
#(
    parameter int DWIDTH             = DWIDTH_DEF,
    parameter int AWIDTH             = AWIDTH_DEF,
    parameter int CHANNELS           = CHANNELS_DEF,
    parameter int ALMOST_FULL_VALUE  = 2**AWIDTH - 3,
    parameter int ALMOST_EMPTY_VALUE = 3,
    localparam int CH_W              = ch_w(CHANNELS)
) (
    input  logic                           clk_i,
    input  logic                           arstn_i,
    input  logic                           wrreq_i,
    input  logic [CH_W-1:0]                wr_ch_i,
    input  logic [DWIDTH-1:0]              data_i,
    input  logic                           rdreq_i,
    input  logic [CH_W-1:0]                rd_ch_i,
    output logic [DWIDTH-1:0]              q_o,
    output logic                           q_valid_o,
    output logic [CH_W-1:0]                q_ch_o,
    input  logic                           clr_err_i,
    output logic [CHANNELS-1:0]            empty_o,
    output logic [CHANNELS-1:0]            full_o,
    output logic [CHANNELS-1:0]            almost_full_o,
    output logic [CHANNELS-1:0]            almost_empty_o,
    output logic [CHANNELS*(AWIDTH+1)-1:0] usedw_o,
    output logic [CHANNELS-1:0]            overflow_o,
    output logic [CHANNELS-1:0]            underflow_o
);

    localparam int UW = AWIDTH + 1;
    localparam logic [AWIDTH:0] DEPTH  = UW'(2**AWIDTH);
    localparam logic [AWIDTH:0] AF_LVL = UW'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0] AE_LVL = UW'(ALMOST_EMPTY_VALUE);

    logic [CHANNELS-1:0][AWIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [CHANNELS-1:0][AWIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [CHANNELS-1:0][AWIDTH:0] usedw_q, usedw_d;
    logic [CHANNELS-1:0]           ovf_q, ovf_d, udf_q, udf_d;
    logic                          wr_acc, rd_acc;
    logic                          q_vld_q, q_seen_q;
    logic [CH_W-1:0]               q_ch_q;
    logic [DWIDTH-1:0]             ram_rdat;

    always_comb begin
        empty_o        = '0;
        full_o         = '0;
        almost_full_o  = '0;
        almost_empty_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            empty_o[c]        = (usedw_q[c] == '0);
            full_o[c]         = (usedw_q[c] == DEPTH);
            almost_full_o[c]  = (usedw_q[c] >= AF_LVL);
            almost_empty_o[c] = (usedw_q[c] <  AE_LVL);
        end
    end

    // Acceptance uses start-of-cycle flags, so read and write never hit one address.
    assign wr_acc = wrreq_i && !full_o[wr_ch_i];
    assign rd_acc = rdreq_i && !empty_o[rd_ch_i];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        if (wr_acc) begin
            wr_ptr_d[wr_ch_i] = wr_ptr_q[wr_ch_i] + UW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d[rd_ch_i] = rd_ptr_q[rd_ch_i] + UW'(1);
        end
        for (int c = 0; c < CHANNELS; c++) begin
            case ({wr_acc && (wr_ch_i == CH_W'(c)), rd_acc && (rd_ch_i == CH_W'(c))})
                2'b10:   usedw_d[c] = usedw_q[c] + UW'(1);
                2'b01:   usedw_d[c] = usedw_q[c] - UW'(1);
                default: usedw_d[c] = usedw_q[c];
            endcase
        end
    end

    always_comb begin
        ovf_d = clr_err_i ? '0 : ovf_q;
        udf_d = clr_err_i ? '0 : udf_q;
        if (wrreq_i && !wr_acc) begin
            ovf_d[wr_ch_i] = 1'b1;
        end
        if (rdreq_i && !rd_acc) begin
            udf_d[rd_ch_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            ovf_q    <= '0;
            udf_q    <= '0;
            q_vld_q  <= 1'b0;
            q_seen_q <= 1'b0;
            q_ch_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            q_vld_q  <= rd_acc;
            if (rd_acc) begin
                q_seen_q <= 1'b1;
                q_ch_q   <= rd_ch_i;
            end
        end
    end

    fifo_mc_ram #(
        .DWIDTH (DWIDTH),
        .ADDR_W (CH_W + AWIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i ({wr_ch_i, wr_ptr_q[wr_ch_i][AWIDTH-1:0]}),
        .wdata_i (data_i),
        .re_i    (rd_acc),
        .raddr_i ({rd_ch_i, rd_ptr_q[rd_ch_i][AWIDTH-1:0]}),
        .rdata_o (ram_rdat)
    );

    // The RAM output register has no reset; mask it until a post-reset read lands.
    assign q_o         = q_seen_q ? ram_rdat : '0;
    assign q_valid_o   = q_vld_q;
    assign q_ch_o      = q_ch_q;
    assign usedw_o     = usedw_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: tb/tb_fifo_mc.sv
// Directed bench for fifo_mc with default parameters (16-bit data, 16 deep, 4 channels).
module tb_fifo_mc;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        wrreq_i, rdreq_i, clr_err_i;
    logic [1:0]  wr_ch_i, rd_ch_i;
    logic [15:0] data_i;
    logic [15:0] q_o;
    logic        q_valid_o;
    logic [1:0]  q_ch_o;
    logic [3:0]  empty_o, full_o, almost_full_o, almost_empty_o;
    logic [19:0] usedw_o;
    logic [3:0]  overflow_o, underflow_o;

    int checks   = 0;
    int failures = 0;

    fifo_mc dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .wrreq_i        (wrreq_i),
        .wr_ch_i        (wr_ch_i),
        .data_i         (data_i),
        .rdreq_i        (rdreq_i),
        .rd_ch_i        (rd_ch_i),
        .q_o            (q_o),
        .q_valid_o      (q_valid_o),
        .q_ch_o         (q_ch_o),
        .clr_err_i      (clr_err_i),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .usedw_o        (usedw_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [4:0] uw(input int c);
        return usedw_o[c*5 +: 5];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic wr, input logic [1:0] wch, input logic [15:0] d,
                       input logic rd, input logic [1:0] rch, input logic clr);
        wrreq_i   = wr;
        wr_ch_i   = wch;
        data_i    = d;
        rdreq_i   = rd;
        rd_ch_i   = rch;
        clr_err_i = clr;
        @(posedge clk_i);
        #1;
        wrreq_i   = 1'b0;
        rdreq_i   = 1'b0;
        clr_err_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"}, empty_o, 4'hF);
        chk({tag, "_full"}, full_o, 4'h0);
        chk({tag, "_afull"}, almost_full_o, 4'h0);
        chk({tag, "_aempty"}, almost_empty_o, 4'hF);
        chk({tag, "_usedw"}, usedw_o, 20'h0);
        chk({tag, "_qvalid"}, q_valid_o, 1'b0);
        chk({tag, "_q"}, q_o, 16'h0);
        chk({tag, "_qch"}, q_ch_o, 2'd0);
        chk({tag, "_ovf"}, overflow_o, 4'h0);
        chk({tag, "_udf"}, underflow_o, 4'h0);
    endtask

    initial begin
        arstn_i = 1'b0; wrreq_i = 1'b0; rdreq_i = 1'b0; clr_err_i = 1'b0;
        wr_ch_i = 2'd0; rd_ch_i = 2'd0; data_i = 16'h0;
        #1;
        chk_reset_outputs("rst");
        @(posedge clk_i);
        @(posedge clk_i);
        #3 arstn_i = 1'b1;

        // Two words through channel 2.
        cyc(1, 2'd2, 16'h0011, 0, 2'd0, 0);
        chk("s1_usedw_a", uw(2), 5'd1);
        chk("s1_empty_a", empty_o[2], 1'b0);
        cyc(1, 2'd2, 16'h0022, 0, 2'd0, 0);
        cyc(0, 2'd0, 16'h0, 1, 2'd2, 0);
        chk("s1_q0", q_o, 16'h0011);
        chk("s1_qv0", q_valid_o, 1'b1);
        chk("s1_qch0", q_ch_o, 2'd2);
        cyc(0, 2'd0, 16'h0, 1, 2'd2, 0);
        chk("s1_q1", q_o, 16'h0022);
        chk("s1_qch1", q_ch_o, 2'd2);
        chk("s1_empty_b", empty_o[2], 1'b1);
        cyc(0, 2'd0, 16'h0, 0, 2'd0, 0);
        chk("s1_idle_qv", q_valid_o, 1'b0);
        chk("s1_idle_hold", q_o, 16'h0022);

        // Fill channel 1, then overflow it.
        for (int i = 0; i < 16; i++) cyc(1, 2'd1, 16'h1100 + 16'(i), 0, 2'd0, 0);
        chk("s2_full", full_o[1], 1'b1);
        chk("s2_usedw", uw(1), 5'd16);
        chk("s2_afull", almost_full_o[1], 1'b1);
        chk("s2_no_ovf", overflow_o, 4'h0);
        cyc(1, 2'd1, 16'hDEAD, 0, 2'd0, 0);
        chk("s2_ovf", overflow_o, 4'b0010);
        chk("s2_usedw_hold", uw(1), 5'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 2'd0, 16'h0, 1, 2'd1, 0);
            chk($sformatf("s2_rd%0d", i), q_o, 16'h1100 + 16'(i));
        end
        chk("s2_empty", empty_o[1], 1'b1);
        cyc(0, 2'd0, 16'h0, 0, 2'd0, 1);
        chk("s2_ovf_clr", overflow_o, 4'h0);

        // Underflow on channel 3, clear, and set-wins-over-clear.
        cyc(0, 2'd0, 16'h0, 1, 2'd3, 0);
        chk("s3_qv", q_valid_o, 1'b0);
        chk("s3_udf", underflow_o, 4'b1000);
        chk("s3_q_hold", q_o, 16'h110F);
        cyc(0, 2'd0, 16'h0, 0, 2'd0, 1);
        chk("s3_udf_clr", underflow_o, 4'h0);
        cyc(0, 2'd0, 16'h0, 1, 2'd3, 1);
        chk("s3_set_wins", underflow_o, 4'b1000);
        cyc(0, 2'd0, 16'h0, 0, 2'd0, 1);
        chk("s3_udf_clr2", underflow_o, 4'h0);

        // Channel 0 held at 5 words through pointer wrap.
        for (int k = 0; k < 5; k++) cyc(1, 2'd0, 16'h0A00 + 16'(k), 0, 2'd0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 2'd0, 16'h0A05 + 16'(i), 1, 2'd0, 0);
            chk($sformatf("s4_q%0d", i), q_o, 16'h0A00 + 16'(i));
            chk($sformatf("s4_uw%0d", i), uw(0), 5'd5);
        end
        chk("s4_ovf", overflow_o, 4'h0);
        chk("s4_udf", underflow_o, 4'h0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 2'd0, 16'h0, 1, 2'd0, 0);
            chk($sformatf("s4_drain%0d", k), q_o, 16'h0A28 + 16'(k));
        end
        chk("s4_empty", empty_o[0], 1'b1);

        // Interleaved channels and almost-flag thresholds.
        cyc(1, 2'd0, 16'hC000, 0, 2'd0, 0);
        cyc(1, 2'd0, 16'hC001, 0, 2'd0, 0);
        for (int i = 0; i < 14; i++) begin
            cyc(1, 2'd3, 16'h3300 + 16'(i), (i < 2), 2'd0, 0);
            chk($sformatf("s5_uw3_%0d", i), uw(3), 5'(i + 1));
            chk($sformatf("s5_ae3_%0d", i), almost_empty_o[3], (i + 1) < 3);
            chk($sformatf("s5_af3_%0d", i), almost_full_o[3], (i + 1) >= 13);
            if (i < 2) chk($sformatf("s5_q0_%0d", i), q_o, 16'hC000 + 16'(i));
        end
        chk("s5_uw0", uw(0), 5'd0);
        cyc(1, 2'd2, 16'h2200, 1, 2'd3, 0);
        chk("s5_qa", q_o, 16'h3300);
        chk("s5_qcha", q_ch_o, 2'd3);
        chk("s5_af3_13", almost_full_o[3], 1'b1);
        chk("s5_uw2", uw(2), 5'd1);
        cyc(1, 2'd1, 16'h1111, 1, 2'd3, 0);
        chk("s5_qb", q_o, 16'h3301);
        chk("s5_af3_12", almost_full_o[3], 1'b0);
        cyc(1, 2'd0, 16'h0B00, 1, 2'd2, 0);
        chk("s5_qc", q_o, 16'h2200);
        chk("s5_qchc", q_ch_o, 2'd2);
        chk("s5_uw0b", uw(0), 5'd1);
        cyc(0, 2'd0, 16'h0, 1, 2'd1, 0);
        chk("s5_qd", q_o, 16'h1111);
        chk("s5_qchd", q_ch_o, 2'd1);
        cyc(0, 2'd0, 16'h0, 1, 2'd0, 0);
        chk("s5_qe", q_o, 16'h0B00);
        for (int j = 0; j < 12; j++) begin
            cyc(0, 2'd0, 16'h0, 1, 2'd3, 0);
            chk($sformatf("s5_d3_%0d", j), q_o, 16'h3302 + 16'(j));
            chk($sformatf("s5_ae3d_%0d", j), almost_empty_o[3], (11 - j) < 3);
        end
        chk("s5_all_empty", empty_o, 4'hF);

        // Asynchronous reset with data queued and a read in flight.
        for (int k = 0; k < 8; k++) cyc(1, 2'd0, 16'h5500 + 16'(k), 0, 2'd0, 0);
        chk("s6_uw0", uw(0), 5'd8);
        cyc(0, 2'd0, 16'h0, 1, 2'd0, 0);
        chk("s6_q", q_o, 16'h5500);
        #2 arstn_i = 1'b0;
        #1;
        chk_reset_outputs("s6rst");
        @(posedge clk_i);
        #3 arstn_i = 1'b1;
        cyc(0, 2'd0, 16'h0, 0, 2'd0, 0);
        chk("s6_qv_after", q_valid_o, 1'b0);
        chk("s6_empty_after", empty_o, 4'b1111);
        cyc(1, 2'd0, 16'h7777, 0, 2'd0, 0);
        chk("s6_uw_new", uw(0), 5'd1);
        cyc(0, 2'd0, 16'h0, 1, 2'd0, 0);
        chk("s6_q_new", q_o, 16'h7777);
        chk("s6_qv_new", q_valid_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_mc.md
FIFO_MC -- requirements
Module: fifo_mc

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DWIDTH, 16, data width in bits.
- AWIDTH, 4, per-channel depth is 2**AWIDTH words.
- CHANNELS, 4, number of independent queues; power of two, >= 2.
- ALMOST_FULL_VALUE, 2**AWIDTH-3, almost_full threshold, same for every channel.
- ALMOST_EMPTY_VALUE, 3, almost_empty threshold, same for every channel.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock.
- arstn_i  in  1  reset; asynchronous, active-low.
- wrreq_i  in  1  write request.
- wr_ch_i  in  CH_W  target channel for the write; CH_W = $clog2(CHANNELS).
- data_i  in  DWIDTH  write data.
- rdreq_i  in  1  read request.
- rd_ch_i  in  CH_W  source channel for the read.
- q_o  out  DWIDTH  read data.
- q_valid_o  out  1  q_o holds accepted read data.
- q_ch_o  out  CH_W  channel that supplied q_o.
- clr_err_i  in  1  clears the sticky error flags.
- empty_o, full_o, almost_full_o, almost_empty_o  out  CHANNELS  per-channel status; bit c belongs to channel c.
- usedw_o  out  CHANNELS*(AWIDTH+1)  per-channel fill level; slice c is [c*(AWIDTH+1) +: AWIDTH+1].
- overflow_o, underflow_o  out  CHANNELS  per-channel sticky error flags.

Function
REQ-003 Each channel SHALL be an independent circular queue holding 2**AWIDTH words, with its own write pointer and read pointer, each AWIDTH+1 bits wide including a wrap bit.
REQ-004 All channels SHALL share one memory of CHANNELS*2**AWIDTH words, addressed as {channel, pointer[AWIDTH-1:0]}.
REQ-005 A write SHALL be accepted when wrreq_i=1 and full_o[wr_ch_i]=0, with full_o taken as its value at the start of the cycle; accepting it stores data_i and advances that channel's write pointer.
REQ-006 A read SHALL be accepted when rdreq_i=1 and empty_o[rd_ch_i]=0, with empty_o taken as its value at the start of the cycle; accepting it advances that channel's read pointer.
REQ-007 Read latency SHALL be exactly 1 cycle: q_o, q_ch_o and q_valid_o=1 are driven on the edge after an accepted read.
REQ-008 After a cycle with no accepted read, q_valid_o SHALL be 0 and q_o/q_ch_o SHALL hold their previous values.
REQ-009 A write and a read SHALL both be accepted in the same cycle, whether they target the same channel or different channels.
- Read and write addresses never collide: reading an empty channel and writing a full channel are both rejected.
REQ-010 Per-channel usedw SHALL be registered, counting from 0 to 2**AWIDTH.
- Accepted write only: +1.
- Accepted read only: -1.
- Both on the same channel: unchanged.
REQ-011 Flags SHALL be combinational functions of the registered usedw.
- empty: usedw==0.
- full: usedw==2**AWIDTH.
- almost_full: usedw>=ALMOST_FULL_VALUE.
- almost_empty: usedw<ALMOST_EMPTY_VALUE.
REQ-012 A rejected write SHALL set overflow_o[wr_ch_i], and a rejected read SHALL set underflow_o[rd_ch_i], on the next edge.
- Memory, pointers and usedw are unchanged by a rejected request.
REQ-013 When clr_err_i=1, all error flags SHALL clear on the next edge.
- A new error in that same cycle wins: that flag is set.
REQ-014 Pointers SHALL wrap modulo 2**(AWIDTH+1) without disturbing data or flags.

Reset
REQ-015 While arstn_i=0, all state SHALL be forced immediately, without waiting for a clock edge:
- pointers and usedw = 0;
- empty_o = all ones;
- full_o and almost_full_o = 0;
- almost_empty_o = all ones;
- q_valid_o, q_o, q_ch_o = 0;
- overflow_o, underflow_o = 0.
REQ-016 Memory contents SHALL NOT be reset; data stored before reset is unreachable after it.
REQ-017 A reset asserted mid-operation SHALL discard all queued data and any read in flight.
- q_valid_o is 0 on the first edge after release.

Structure
REQ-018 Package fifo_pkg SHALL hold the default DWIDTH, AWIDTH and CHANNELS constants and a clog2-based CH_W helper.
REQ-019 The shared memory SHALL be a sub-module, fifo_mc_ram: simple dual-port, registered read, one write port and one read port, no reset, inferable as block RAM.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write 0x0011, 0x0022 to ch 2, then read ch 2 twice -> q_o = 0x0011 then 0x0022, q_ch_o=2, one cycle after each read; empty_o[2] returns to 1.
- Fill ch 1 with 16 words (AWIDTH=4), then write once more -> full_o[1]=1, usedw slice 1 = 16, overflow_o[1]=1; the extra word is dropped and the read-back sequence matches the 16 written.
- Read empty ch 3 -> q_valid_o=0, underflow_o[3]=1; pulse clr_err_i -> underflow_o[3]=0.
- Hold ch 0 at usedw=5 while writing and reading it in the same cycle for 40 cycles (pointer wrap) -> usedw stays 5, data in FIFO order, no error flags.
- Interleave writes to ch 0..3 with reads from other channels -> each channel's order and usedw are independent; almost_empty/almost_full toggle exactly at 3 and 13.
- Assert arstn_i between clock edges with ch 0 holding 8 words -> all outputs take their reset values immediately; after release, empty_o = 4'b1111.
